// File: rtl/depth_seq_gate.sv
// depth_seq_gate: per-symbol order-book sequence gate.
// Forwards SNAP/DELTA events in order, drops stale and unsynced ones.
module depth_seq_gate #(
  parameter int NUM_SYM    = 4,
  parameter int SYM_W      = 16,
  parameter int PRICE_W    = 32,
  parameter int QTY_W      = 32,
  parameter int FIFO_DEPTH = 8,
  localparam int EV_W      = 2 + 1 + SYM_W + 64 + 64
                             + PRICE_W + QTY_W + 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sync_clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [EV_W-1:0]    in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [EV_W-1:0]    out_data,
  output logic [NUM_SYM-1:0] sym_synced,
  output logic               resync_req,
  output logic [SYM_W-1:0]   resync_sym,
  output logic [31:0]        drop_cnt,
  output logic [31:0]        gap_cnt
);

  localparam int F_QTY  = 8;
  localparam int F_PRC  = F_QTY + QTY_W;
  localparam int F_UID  = F_PRC + PRICE_W;
  localparam int F_TS   = F_UID + 64;
  localparam int F_SYM  = F_TS + 64;
  localparam int F_SIDE = F_SYM + SYM_W;
  localparam int F_REC  = F_SIDE + 1;
  localparam int IW     = (NUM_SYM > 1) ? $clog2(NUM_SYM) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);

  typedef enum logic {UNSYNC, SYNCED} sym_st_e;
  typedef enum logic [1:0] {
    C_NONE, C_PUSH, C_DROP, C_GAP
  } cls_e;

  sym_st_e       st      [NUM_SYM];
  logic [63:0]   last_id [NUM_SYM];

  logic [1:0]       rec;
  logic [SYM_W-1:0] sym;
  logic [63:0]      uid;
  logic [IW-1:0]    idx;
  logic             sym_ok;
  logic             acc;
  sym_st_e          cur;
  logic [63:0]      last;
  logic [63:0]      nxt;
  cls_e             cls;

  logic [EV_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]     wp;
  logic [AW:0]     rp;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            ready_en;

  assign rec    = in_data[F_REC +: 2];
  assign sym    = in_data[F_SYM +: SYM_W];
  assign uid    = in_data[F_UID +: 64];
  assign idx    = sym[IW-1:0];
  assign sym_ok = sym < SYM_W'(NUM_SYM);
  assign acc    = in_valid && in_ready;

  // Classify the accepted event against the current per-symbol state.
  always_comb begin
    cur  = st[idx];
    last = last_id[idx];
    nxt  = last + 64'd1;
    cls  = C_NONE;
    if (acc) begin
      priority case (1'b1)
        (!sym_ok || rec[1]):        cls = C_DROP;
        (rec == 2'b00):             cls = C_PUSH;
        (cur == UNSYNC):            cls = C_DROP;
        (uid == last || uid == nxt): cls = C_PUSH;
        (uid > last):               cls = C_GAP;
        default:                    cls = C_DROP;
      endcase
    end
  end

  // Per-symbol sync state; a clear pulse overrides any same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SYM; i++) begin
        st[i]      <= UNSYNC;
        last_id[i] <= '0;
      end
    end else begin
      if (cls == C_PUSH) begin
        last_id[idx] <= uid;
        if (rec == 2'b00)
          st[idx] <= SYNCED;
      end
      if (cls == C_GAP)
        st[idx] <= UNSYNC;
      if (sync_clear)
        for (int i = 0; i < NUM_SYM; i++)
          st[i] <= UNSYNC;
    end
  end

  // Expose the sync state vector.
  always_comb begin
    for (int i = 0; i < NUM_SYM; i++)
      sym_synced[i] = (st[i] == SYNCED);
  end

  // Statistics and the resync request pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt   <= '0;
      gap_cnt    <= '0;
      resync_req <= 1'b0;
      resync_sym <= '0;
    end else begin
      resync_req <= (cls == C_GAP);
      if (cls == C_GAP)
        resync_sym <= sym;
      if (cls == C_DROP && drop_cnt != 32'hFFFF_FFFF)
        drop_cnt <= drop_cnt + 32'd1;
      if (cls == C_GAP && gap_cnt != 32'hFFFF_FFFF)
        gap_cnt <= gap_cnt + 32'd1;
    end
  end

  assign push      = (cls == C_PUSH);
  assign pop       = out_valid && out_ready;
  assign empty     = (wp == rp);
  assign full      = (wp[AW] != rp[AW])
                  && (wp[AW-1:0] == rp[AW-1:0]);
  assign in_ready  = ready_en && !full;
  assign out_valid = !empty;
  assign out_data  = mem[rp[AW-1:0]];

  // Input stays blocked until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ready_en <= 1'b0;
    else
      ready_en <= 1'b1;
  end

  // FIFO storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wp[AW-1:0]] <= in_data;
  end

  // FIFO pointers with an extra wrap bit for full/empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push)
        wp <= wp + 1'b1;
      if (pop)
        rp <= rp + 1'b1;
    end
  end

endmodule

// File: tb/tb_depth_seq_gate.sv
// tb_depth_seq_gate: table-driven and scoreboard bench
// for depth_seq_gate at default parameters.
module tb_depth_seq_gate;

  localparam int EV_W = 2 + 1 + 16 + 64 + 64 + 32 + 32 + 8;

  logic            clk;
  logic            rst_n;
  logic            sync_clear;
  logic            in_valid;
  logic            in_ready;
  logic [EV_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [EV_W-1:0] out_data;
  logic [3:0]      sym_synced;
  logic            resync_req;
  logic [15:0]     resync_sym;
  logic [31:0]     drop_cnt;
  logic [31:0]     gap_cnt;

  int errors;
  int checks;

  logic [EV_W-1:0] q[$];
  logic [EV_W-1:0] held;
  bit              held_v;

  depth_seq_gate dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sync_clear (sync_clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sym_synced (sym_synced),
    .resync_req (resync_req),
    .resync_sym (resync_sym),
    .drop_cnt   (drop_cnt),
    .gap_cnt    (gap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  r;
    logic [15:0] s;
    logic [63:0] u;
    bit          push;
    int          dinc;
    int          ginc;
    logic [3:0]  syn;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [255:0] a,
                     input logic [255:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic logic [EV_W-1:0] ev(
    input logic [1:0] r, input logic [15:0] s,
    input logic [63:0] u);
    logic [63:0] ts;
    ts = 64'h1000_0000_0000 ^ u;
    return {r, s[0], s, ts, u, u[31:0] ^ 32'h5A5A_0000,
            32'h0000_0C00 + u[31:0], 8'hA5};
  endfunction

  function automatic vec_t mk(
    input logic [1:0] r, input logic [15:0] s,
    input logic [63:0] u, input bit p, input int d,
    input int g, input logic [3:0] y);
    vec_t v;
    v.r = r; v.s = s; v.u = u; v.push = p;
    v.dinc = d; v.ginc = g; v.syn = y;
    return v;
  endfunction

  // Drive one event; wait (bounded) for in_ready.
  task automatic send(input logic [EV_W-1:0] e,
                      input bit p, input bit clr);
    int n;
    n = 0;
    in_data    = e;
    in_valid   = 1'b1;
    sync_clear = clr;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end else if (p) begin
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    sync_clear = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && q.size() != 0; k++)
      @(posedge clk);
    #1;
    chk("drain_queue_empty", 256'(q.size()), 256'd0);
  endtask

  // Scoreboard: compare each popped head; check hold under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      if (held_v && out_valid)
        chk("hold_stable", 256'(out_data), 256'(held));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %0h expected none",
                   out_data);
        end else begin
          chk("out_data", 256'(out_data), 256'(q.pop_front()));
        end
      end
      held_v = out_valid && !out_ready;
      held   = out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"},  256'(out_valid),  256'd0);
    chk({tag, "_in_ready"},   256'(in_ready),   256'd0);
    chk({tag, "_sym_synced"}, 256'(sym_synced), 256'd0);
    chk({tag, "_resync_req"}, 256'(resync_req), 256'd0);
    chk({tag, "_resync_sym"}, 256'(resync_sym), 256'd0);
    chk({tag, "_drop_cnt"},   256'(drop_cnt),   256'd0);
    chk({tag, "_gap_cnt"},    256'(gap_cnt),    256'd0);
  endtask

  vec_t tbl[16];
  int   exp_drop;
  int   exp_gap;
  logic [EV_W-1:0] e9;

  initial begin
    errors     = 0;
    checks     = 0;
    exp_drop   = 0;
    exp_gap    = 0;
    rst_n      = 1'b0;
    sync_clear = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;

    tbl[0]  = mk(2'b00, 16'd1, 64'd100, 1, 0, 0, 4'b0010);
    tbl[1]  = mk(2'b01, 16'd1, 64'd100, 1, 0, 0, 4'b0010);
    tbl[2]  = mk(2'b01, 16'd1, 64'd101, 1, 0, 0, 4'b0010);
    tbl[3]  = mk(2'b01, 16'd1, 64'd101, 1, 0, 0, 4'b0010);
    tbl[4]  = mk(2'b01, 16'd1, 64'd102, 1, 0, 0, 4'b0010);
    tbl[5]  = mk(2'b01, 16'd0, 64'd7,   0, 1, 0, 4'b0010);
    tbl[6]  = mk(2'b00, 16'd0, 64'd5,   1, 0, 0, 4'b0011);
    tbl[7]  = mk(2'b01, 16'd0, 64'd3,   0, 1, 0, 4'b0011);
    tbl[8]  = mk(2'b00, 16'd2, 64'd10,  1, 0, 0, 4'b0111);
    tbl[9]  = mk(2'b01, 16'd2, 64'd13,  0, 0, 1, 4'b0011);
    tbl[10] = mk(2'b01, 16'd2, 64'd14,  0, 1, 0, 4'b0011);
    tbl[11] = mk(2'b00, 16'd3, '1,      1, 0, 0, 4'b1011);
    tbl[12] = mk(2'b01, 16'd3, 64'd0,   1, 0, 0, 4'b1011);
    tbl[13] = mk(2'b00, 16'd5, 64'd1,   0, 1, 0, 4'b1011);
    tbl[14] = mk(2'b10, 16'd1, 64'd103, 0, 1, 0, 4'b1011);
    tbl[15] = mk(2'b11, 16'd1, 64'd103, 0, 1, 0, 4'b1011);

    #3;
    chk_reset_vals("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 256'(in_ready), 256'd0);
    @(posedge clk); #1;
    chk("ready_after_edge", 256'(in_ready), 256'd1);

    for (int i = 0; i < 16; i++) begin
      send(ev(tbl[i].r, tbl[i].s, tbl[i].u), tbl[i].push, 1'b0);
      exp_drop += tbl[i].dinc;
      exp_gap  += tbl[i].ginc;
      chk($sformatf("v%0d_out_valid", i),
          256'(out_valid), 256'(tbl[i].push));
      chk($sformatf("v%0d_sym_synced", i),
          256'(sym_synced), 256'(tbl[i].syn));
      chk($sformatf("v%0d_drop_cnt", i),
          256'(drop_cnt), 256'(exp_drop));
      chk($sformatf("v%0d_gap_cnt", i),
          256'(gap_cnt), 256'(exp_gap));
      chk($sformatf("v%0d_resync_req", i),
          256'(resync_req), 256'(tbl[i].ginc));
      if (tbl[i].ginc != 0)
        chk($sformatf("v%0d_resync_sym", i),
            256'(resync_sym), 256'(tbl[i].s));
    end
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      send(ev(2'b00, 16'd1, 64'(200 + i)), 1'b1, 1'b0);
    chk("bp_full_ready", 256'(in_ready), 256'd0);
    chk("bp_full_valid", 256'(out_valid), 256'd1);
    e9       = ev(2'b00, 16'd1, 64'd208);
    in_data  = e9;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("bp_still_blocked", 256'(in_ready), 256'd0);
    out_ready = 1'b1;
    send(e9, 1'b1, 1'b0);
    drain();

    send(ev(2'b01, 16'd1, 64'd209), 1'b1, 1'b1);
    chk("clr_fwd_valid", 256'(out_valid), 256'd1);
    chk("clr_sym_synced", 256'(sym_synced), 256'd0);
    chk("clr_drop_same", 256'(drop_cnt), 256'(exp_drop));
    send(ev(2'b01, 16'd1, 64'd210), 1'b0, 1'b0);
    exp_drop++;
    chk("post_clr_drop", 256'(drop_cnt), 256'(exp_drop));
    drain();

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(ev(2'b00, 16'd2, 64'(300 + i)), 1'b1, 1'b0);
    chk("mid_valid_pre", 256'(out_valid), 256'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", 256'(in_ready), 256'd1);
    chk("midrst_empty", 256'(out_valid), 256'd0);
    out_ready = 1'b1;
    send(ev(2'b00, 16'd0, 64'd42), 1'b1, 1'b0);
    chk("midrst_sync0", 256'(sym_synced), 256'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/depth_seq_gate.md
DEPTH_SEQ_GATE -- requirements
Module: depth_seq_gate

Interface
REQ-001 SHALL have parameter NUM_SYM, default 4: number of tracked symbols, 1..16.
REQ-002 SHALL have parameter SYM_W, default 16: symbol_id width.
REQ-003 SHALL have parameter PRICE_W, default 32: fixed-point price width.
REQ-004 SHALL have parameter QTY_W, default 32: fixed-point qty width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8: output FIFO entries, power of 2, >=2.
REQ-006 SHALL define EV_W = 2+1+SYM_W+64+64+PRICE_W+QTY_W+8, with event packed MSB-first as {rec_type, side, symbol_id, ts_rx_ns, update_id, price, qty, flags}; rec_type 00=SNAP, 01=DELTA.
REQ-007 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port sync_clear  input  1  one-cycle pulse; forces every symbol to UNSYNC.
REQ-010 SHALL have port in_valid  input  1  input event valid.
REQ-011 SHALL have port in_ready  output  1  block accepts the event this cycle.
REQ-012 SHALL have port in_data  input  EV_W  input event.
REQ-013 SHALL have port out_valid  output  1  FIFO head valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts the head.
REQ-015 SHALL have port out_data  output  EV_W  FIFO head event.
REQ-016 SHALL have port sym_synced  output  NUM_SYM  bit i = symbol i in SYNCED.
REQ-017 SHALL have port resync_req  output  1  one-cycle pulse on gap detection.
REQ-018 SHALL have port resync_sym  output  SYM_W  symbol of the last resync_req; held between pulses.
REQ-019 SHALL have port drop_cnt  output  32  saturating count of dropped events.
REQ-020 SHALL have port gap_cnt  output  32  saturating count of detected gaps.

Function
REQ-021 SHALL accept on in_valid && in_ready; in_ready = !fifo_full, with no full-plus-pop pass-through.
REQ-022 SHALL keep per symbol a state (UNSYNC/SYNCED) and last_id[63:0].
REQ-023 SHALL drop and count events with symbol_id >= NUM_SYM or rec_type in {10,11}; no state change.
REQ-024 SHALL on SNAP set last_id = update_id and state = SYNCED, and push the event, from either state.
REQ-025 SHALL on DELTA in UNSYNC drop it and increment drop_cnt.
REQ-026 SHALL on DELTA in SYNCED with update_id == last_id or update_id == last_id+1 (mod 2^64) push the event and set last_id = update_id.
REQ-027 SHALL on DELTA in SYNCED with update_id < last_id (unsigned), excluding the wrap case of REQ-026, drop it and increment drop_cnt; no state change.
REQ-028 SHALL on DELTA in SYNCED with update_id > last_id+1 drop it and: increment gap_cnt; set state = UNSYNC; pulse resync_req the next cycle; set resync_sym = symbol_id.
REQ-029 SHALL not modify the pushed event; out_data is bit-identical to in_data.
REQ-030 SHALL make a pushed event visible on out_valid/out_data the cycle after acceptance (FWFT, latency 1).
REQ-031 SHALL pop the head on out_valid && out_ready, and hold out_data stable while out_valid && !out_ready.
REQ-032 SHALL allow push and pop in the same cycle when not full, with occupancy unchanged.
REQ-033 SHALL saturate drop_cnt and gap_cnt at 32'hFFFF_FFFF.
REQ-034 SHALL classify an event that coincides with sync_clear against the pre-clear state; the event is pushed or dropped accordingly, then all states become UNSYNC (clear wins over any state update).
REQ-035 SHALL leave FIFO contents, last_id values and counters unchanged on sync_clear.

Reset
REQ-036 SHALL while rst_n=0 asynchronously force: FIFO empty; out_valid=0; in_ready=0; all states UNSYNC; last_id=0; sym_synced=0; resync_req=0; resync_sym=0; drop_cnt=0; gap_cnt=0.
REQ-037 SHALL drive in_ready=1 from the first clk edge after rst_n deasserts, and discard any reset mid-stream with no partial output.

Verification
REQ-038 SHALL verify: SNAP sym1 id=100, then DELTA ids 100,101,101,102 -> all 5 events out in order, 1-cycle latency, sym_synced[1]=1.
REQ-039 SHALL verify: DELTA sym0 before any SNAP -> dropped, drop_cnt=1, out_valid stays 0; then SNAP id=5 and DELTA id=3 -> SNAP out, DELTA dropped, drop_cnt=2.
REQ-040 SHALL verify: SNAP sym2 id=10, DELTA id=13 -> dropped, gap_cnt=1, resync_req pulse, resync_sym=2, sym_synced[2]=0; DELTA id=14 -> dropped.
REQ-041 SHALL verify: SNAP id=2^64-1, DELTA id=0 -> both forwarded.
REQ-042 SHALL verify: out_ready=0 with 9 valid events at FIFO_DEPTH=8 -> in_ready=0 after 8; release -> 9 events out in order, none lost.
REQ-043 SHALL verify: sync_clear coincident with a valid DELTA on a SYNCED symbol -> DELTA forwarded, sym_synced=0 next cycle; rst_n pulse mid-stream -> all outputs at REQ-036 values.
